i2s_tx_module: RTL and testbench
================================

I2S_TX_MODULE -- requirements
Module: i2s_tx_module

Interface
REQ-001 Parameter FRAME_RES, default 32: bck periods per channel slot; a frame is 2*FRAME_RES bck periods.
REQ-002 Parameter DATA_RES, default 24: sample width; SHALL satisfy 1 <= DATA_RES <= FRAME_RES-1.
REQ-003 Parameter BCK_DIV, default 4: clk_i cycles per bck period; SHALL be even and >= 2.
REQ-004 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 left_i  input  DATA_RES  left sample, two's complement, MSB first on the wire.
REQ-007 right_i  input  DATA_RES  right sample, same format.
REQ-008 valid_i  input  1  left_i/right_i hold a stereo pair.
REQ-009 ready_o  output  1  pending register empty; a pair is accepted on a clk_i edge with valid_i & ready_o.
REQ-010 bck_o  output  1  I2S bit clock, registered.
REQ-011 lrck_o  output  1  I2S word select: 0 = left slot, 1 = right slot, registered.
REQ-012 dat_o  output  1  I2S serial data, registered.
REQ-013 underrun_o  output  1  one-clk_i pulse when a frame starts with no pending pair.

Function
REQ-014 Divider div_cnt counts 0..BCK_DIV-1 and wraps; bck_o SHALL be 0 while next div_cnt < BCK_DIV/2, else 1.
REQ-015 Bit boundary = clk_i edge where div_cnt wraps BCK_DIV-1 -> 0; bck_o falls on this edge, and lrck_o/dat_o SHALL change only on this edge.
REQ-016 Slot bit index b counts 0..FRAME_RES-1 per slot; left slot then right slot; at b=0 of a slot, lrck_o SHALL take that slot's value.
REQ-017 dat_o at slot bit b SHALL be sample bit DATA_RES-b for 1 <= b <= DATA_RES, and 0 for b=0 and b > DATA_RES (MSB one bck after the lrck edge, standard I2S).
REQ-018 One-entry pending register holds an accepted pair; ready_o SHALL be registered and equal ~pending_full.
REQ-019 At the boundary entering left-slot b=0: if pending_full, copy pair into the working register and clear pending_full (ready_o = 1 from the next edge); else load zeros into the working register and pulse underrun_o for that one clk_i cycle.
REQ-020 Handshake on the same edge as an empty-pending frame start: underrun is flagged, zeros are sent for that frame, and the new pair goes to pending for the next frame.
REQ-021 The working register SHALL stay stable for the whole frame; left_i/right_i changes after acceptance SHALL have no effect.
REQ-022 Latency: a pair accepted before a left-slot start appears MSB-first on dat_o from the next boundary (b=1) onward.
REQ-023 The pending register SHALL never be overwritten while pending_full is set.

Reset
REQ-024 While rst_i = 1: div_cnt=0, bck_o=0, lrck_o=1, dat_o=0, ready_o=1, underrun_o=0, pending_full=0, working register=0, state = right slot with b=FRAME_RES-1.
REQ-025 The first boundary SHALL be the BCK_DIV-th clk_i rising edge after rst_i deasserts, entering left-slot b=0 (lrck_o 1->0) with the REQ-019 consume/underrun check.
REQ-026 Asserting rst_i mid-frame SHALL discard the pending and working data immediately; after release, behaviour SHALL be identical to power-up.

Verification (FRAME_RES=32, DATA_RES=24, BCK_DIV=4)
REQ-027 Hold rst_i high -> bck_o=0, lrck_o=1, dat_o=0, ready_o=1, underrun_o=0. Release -> bck_o period 4 clk_i, 50% duty, lrck_o period 256 clk_i, first lrck fall on the 4th edge.
REQ-028 Present left=0xA5A5A5, right=0x5A5A5A before the first boundary -> underrun_o=0. A bench decoder sampling dat_o on bck_o rising edges recovers 0xA5A5A5 (lrck=0) and 0x5A5A5A (lrck=1), with bits 25..31 and bit 0 of each slot = 0.
REQ-029 Never assert valid_i -> dat_o constant 0; exactly one underrun_o pulse per 256 clk_i, each on the lrck_o 1->0 edge.
REQ-030 Hold valid_i high with pairs P1, P2, P3 -> ready_o drops after P1 and re-rises only after each left-slot start. The pairs are sent in order in consecutive frames, none is lost or repeated, and underrun_o stays 0.
REQ-031 Assert valid_i (0x7FFFFF/0x800000) exactly on the frame-start edge with pending empty -> underrun_o pulses, that frame sends zeros, and the next frame sends 0x7FFFFF/0x800000.
REQ-032 Pulse rst_i at right-slot b=10 with a pair pending -> outputs return to the REQ-024 values at once; after release the REQ-027 timing repeats and the discarded pair is never transmitted.

Source files
------------

// File: rtl/i2s_tx_module.sv
// I2S transmitter: stereo pairs in via valid/ready, sent MSB-first one bck after each lrck edge.
// Latency: a pair accepted before a frame start is sent in that frame. ready_o is low while the pair waits.
module i2s_tx_module #(
  parameter int FRAME_RES = 32,
  parameter int DATA_RES  = 24,
  parameter int BCK_DIV   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATA_RES-1:0] left_i,
  input  logic [DATA_RES-1:0] right_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic                bck_o,
  output logic                lrck_o,
  output logic                dat_o,
  output logic                underrun_o
);

  localparam int DW = $clog2(BCK_DIV);
  localparam int BW = $clog2(FRAME_RES);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_RES - 1);

  typedef enum logic {SLOT_LEFT = 1'b0, SLOT_RIGHT = 1'b1} slot_e;

  slot_e               slot_q, slot_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DW-1:0]       div_q, div_d;
  logic                boundary, frame_start, accept;
  logic                pend_full_q, pend_full_d;
  logic [DATA_RES-1:0] pend_l_q, pend_r_q;
  logic [DATA_RES-1:0] work_l_q, work_r_q, work_l_d, work_r_d;
  logic [DATA_RES-1:0] word_sel;
  logic                dat_d;

  assign boundary    = (div_q == DIV_LAST);
  assign div_d       = boundary ? '0 : div_q + DW'(1);
  assign frame_start = boundary && (slot_q == SLOT_RIGHT) && (bit_q == BIT_LAST);
  assign accept      = valid_i && ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= SLOT_RIGHT;
      bit_q  <= BIT_LAST;
    end else begin
      slot_q <= slot_d;
      bit_q  <= bit_d;
    end
  end

  always_comb begin
    slot_d      = slot_q;
    bit_d       = bit_q;
    work_l_d    = work_l_q;
    work_r_d    = work_r_q;
    pend_full_d = pend_full_q;
    if (boundary) begin
      if (bit_q == BIT_LAST) begin
        bit_d  = '0;
        slot_d = (slot_q == SLOT_LEFT) ? SLOT_RIGHT : SLOT_LEFT;
      end else begin
        bit_d = bit_q + BW'(1);
      end
    end
    // An empty pending slot at frame start sends a silent frame.
    if (frame_start) begin
      pend_full_d = 1'b0;
      work_l_d    = pend_full_q ? pend_l_q : '0;
      work_r_d    = pend_full_q ? pend_r_q : '0;
    end
    if (accept) pend_full_d = 1'b1;
    word_sel = (slot_d == SLOT_LEFT) ? work_l_d : work_r_d;
    dat_d    = 1'b0;
    for (int i = 0; i < DATA_RES; i++) begin
      if (int'(bit_d) == DATA_RES - i) dat_d = word_sel[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q       <= '0;
      pend_full_q <= 1'b0;
      pend_l_q    <= '0;
      pend_r_q    <= '0;
      work_l_q    <= '0;
      work_r_q    <= '0;
      ready_o     <= 1'b1;
      bck_o       <= 1'b0;
      lrck_o      <= 1'b1;
      dat_o       <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      div_q       <= div_d;
      pend_full_q <= pend_full_d;
      work_l_q    <= work_l_d;
      work_r_q    <= work_r_d;
      ready_o     <= ~pend_full_d;
      bck_o       <= (div_d >= DIV_HALF);
      underrun_o  <= frame_start & ~pend_full_q;
      if (accept) begin
        pend_l_q <= left_i;
        pend_r_q <= right_i;
      end
      if (boundary) begin
        lrck_o <= (slot_d == SLOT_RIGHT);
        dat_o  <= dat_d;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_module.sv
// Bench for i2s_tx_module: frame-level reference model plus a bck-edge decoder of the serial stream.
module tb_i2s_tx_module;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] left_i = '0;
  logic [23:0] right_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o, bck_o, lrck_o, dat_o, underrun_o;

  int tests = 0;
  int fails = 0;

  i2s_tx_module #(.FRAME_RES(32), .DATA_RES(24), .BCK_DIV(4)) dut (
    .clk_i(clk), .rst_i(rst), .left_i(left_i), .right_i(right_i), .valid_i(valid_i),
    .ready_o(ready_o), .bck_o(bck_o), .lrck_o(lrck_o), .dat_o(dat_o), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  // Model state: frames start every 256 clocks from the 4th edge after release.
  int          edge_n = 0;
  logic        m_pend_full = 1'b0, m_ready = 1'b1;
  logic [47:0] m_pend = '0;
  logic [47:0] exp_q[$];
  logic [63:0] rx_q[$];
  logic        m_acc, m_fs, m_exp_ur, m_exp_bck, m_exp_lrck;
  int          ready_err = 0, ur_err = 0, bck_err = 0, lrck_err = 0, edge_err = 0;
  int          dat_ones = 0, ur_seen = 0, ur_exp_cnt = 0;
  logic        prev_bck = 1'b0, prev_lrck = 1'b1, prev_dat = 1'b0;
  logic        mon_last_lrck = 1'b1, mon_have_left = 1'b0;
  logic [31:0] mon_word = '0, mon_left = '0;
  int          mon_bits = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_n = 0; m_pend_full = 1'b0; m_ready = 1'b1;
      exp_q.delete(); rx_q.delete();
      ready_err = 0; ur_err = 0; bck_err = 0; lrck_err = 0; edge_err = 0;
      dat_ones = 0; ur_seen = 0; ur_exp_cnt = 0;
      prev_bck = 1'b0; prev_lrck = 1'b1; prev_dat = 1'b0;
      mon_last_lrck = 1'b1; mon_have_left = 1'b0; mon_bits = 0; mon_word = '0;
    end else begin
      edge_n++;
      m_acc    = valid_i && m_ready;
      m_fs     = (edge_n >= 4) && ((edge_n - 4) % 256 == 0);
      m_exp_ur = 1'b0;
      if (m_fs) begin
        if (m_pend_full) begin
          exp_q.push_back(m_pend);
          m_pend_full = 1'b0;
        end else begin
          exp_q.push_back('0);
          m_exp_ur = 1'b1;
          ur_exp_cnt++;
        end
      end
      if (m_acc) begin
        m_pend = {left_i, right_i};
        m_pend_full = 1'b1;
      end
      m_ready    = !m_pend_full;
      m_exp_bck  = ((edge_n % 4) >= 2);
      m_exp_lrck = (edge_n < 4) ? 1'b1 : ((((edge_n - 4) / 128) % 2) == 1);
      #1;
      if (ready_o !== m_ready) ready_err++;
      if (underrun_o !== m_exp_ur) ur_err++;
      if (underrun_o === 1'b1) ur_seen++;
      if (bck_o !== m_exp_bck) bck_err++;
      if (lrck_o !== m_exp_lrck) lrck_err++;
      if ((lrck_o !== prev_lrck || dat_o !== prev_dat) && !(prev_bck === 1'b1 && bck_o === 1'b0))
        edge_err++;
      if (dat_o === 1'b1) dat_ones++;
      if (prev_bck === 1'b0 && bck_o === 1'b1) begin
        if (lrck_o !== mon_last_lrck) begin
          mon_bits = 0;
          mon_last_lrck = lrck_o;
        end
        mon_word = {mon_word[30:0], dat_o};
        mon_bits++;
        if (mon_bits == 32) begin
          if (lrck_o == 1'b0) begin
            mon_left = mon_word;
            mon_have_left = 1'b1;
          end else if (mon_have_left) begin
            rx_q.push_back({mon_left, mon_word});
            mon_have_left = 1'b0;
          end
        end
      end
      prev_bck = bck_o; prev_lrck = lrck_o; prev_dat = dat_o;
    end
  end

  // Slot on the wire: bit 0 idle, then the 24 sample bits MSB first, then 7 zero bits.
  function automatic logic [63:0] enc(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1; valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic wait_edge(input int target);
    int g;
    g = 0;
    while (edge_n < target && g < 4000) begin
      @(posedge clk); #2;
      g++;
    end
    if (edge_n < target) begin
      tests++; fails++;
      $display("FAIL wait_edge reached %0d need %0d", edge_n, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0;
    repeat (3) @(posedge clk); #2;
    tests++; if (bck_o !== 1'b0) begin fails++; $display("FAIL reset_bck got %b want 0", bck_o); end
    tests++; if (lrck_o !== 1'b1) begin fails++; $display("FAIL reset_lrck got %b want 1", lrck_o); end
    tests++; if (dat_o !== 1'b0) begin fails++; $display("FAIL reset_dat got %b want 0", dat_o); end
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready_o); end
    tests++; if (underrun_o !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b want 0", underrun_o); end
  endtask

  task automatic test_idle();
    int first;
    first = -1;
    do_reset();
    for (int k = 0; k < 20 && first < 0; k++) begin
      @(posedge clk); #2;
      if (lrck_o === 1'b0) first = edge_n;
    end
    tests++; if (first != 4) begin fails++; $display("FAIL idle_first_lrck_fall got edge %0d want 4", first); end
    wait_edge(771);
    tests++; if (bck_err != 0 || lrck_err != 0) begin
      fails++; $display("FAIL idle_clocks bck_err %0d lrck_err %0d want 0", bck_err, lrck_err);
    end
    tests++; if (edge_err != 0) begin fails++; $display("FAIL idle_change_edge got %0d want 0", edge_err); end
    tests++; if (dat_ones != 0) begin fails++; $display("FAIL idle_dat_ones got %0d want 0", dat_ones); end
    tests++; if (ur_seen != 3 || ur_err != 0) begin
      fails++; $display("FAIL idle_underrun got %0d pulses (%0d misplaced) want 3", ur_seen, ur_err);
    end
    tests++; if (rx_q.size() < 3) begin fails++; $display("FAIL idle_frames got %0d want 3", rx_q.size()); end
    else for (int k = 0; k < 3; k++) begin
      tests++; if (rx_q[k] !== enc(24'h0, 24'h0)) begin
        fails++; $display("FAIL idle_frame%0d got %h want %h", k, rx_q[k], enc(24'h0, 24'h0));
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    left_i = 24'hA5A5A5; right_i = 24'h5A5A5A; valid_i = 1'b1;
    @(posedge clk); #2;
    valid_i = 1'b0; left_i = 24'hFFFFFF; right_i = 24'h000000;
    wait_edge(5);
    tests++; if (ur_seen != 0) begin fails++; $display("FAIL single_no_underrun got %0d want 0", ur_seen); end
    wait_edge(515);
    tests++; if (rx_q.size() < 2) begin fails++; $display("FAIL single_frames got %0d want 2", rx_q.size()); end
    else begin
      tests++; if (rx_q[0] !== enc(24'hA5A5A5, 24'h5A5A5A)) begin
        fails++; $display("FAIL single_frame0 got %h want %h", rx_q[0], enc(24'hA5A5A5, 24'h5A5A5A));
      end
      tests++; if (rx_q[1] !== enc(24'h0, 24'h0)) begin
        fails++; $display("FAIL single_frame1 got %h want %h", rx_q[1], enc(24'h0, 24'h0));
      end
    end
    tests++; if (ur_seen != 1 || ready_err != 0 || ur_err != 0 || edge_err != 0) begin
      fails++; $display("FAIL single_protocol ur %0d ready_err %0d ur_err %0d edge_err %0d want 1/0/0/0",
                        ur_seen, ready_err, ur_err, edge_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] pl [0:2];
    logic [23:0] pr [0:2];
    logic        rdy_s;
    int          idx, g;
    pl[0] = 24'h123456; pr[0] = 24'h654321;
    pl[1] = 24'hABCDEF; pr[1] = 24'hFEDCBA;
    pl[2] = 24'h800001; pr[2] = 24'h7FFFFE;
    do_reset();
    idx = 0; g = 0;
    valid_i = 1'b1; left_i = pl[0]; right_i = pr[0];
    rdy_s = ready_o;
    while (idx < 3 && g < 2000) begin
      @(posedge clk); #2;
      g++;
      if (rdy_s) begin
        if (idx == 0) begin
          tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL b2b_ready_drop got %b want 0", ready_o); end
        end
        idx++;
        if (idx < 3) begin
          left_i = pl[idx]; right_i = pr[idx];
        end else begin
          valid_i = 1'b0;
        end
      end
      rdy_s = ready_o;
    end
    valid_i = 1'b0;
    tests++; if (idx != 3) begin fails++; $display("FAIL b2b_accepts got %0d want 3", idx); end
    wait_edge(771);
    tests++; if (rx_q.size() < 3) begin fails++; $display("FAIL b2b_frames got %0d want 3", rx_q.size()); end
    else for (int k = 0; k < 3; k++) begin
      tests++; if (rx_q[k] !== enc(pl[k], pr[k])) begin
        fails++; $display("FAIL b2b_frame%0d got %h want %h", k, rx_q[k], enc(pl[k], pr[k]));
      end
    end
    tests++; if (ur_seen != 0 || ready_err != 0) begin
      fails++; $display("FAIL b2b_flow underrun %0d ready_err %0d want 0/0", ur_seen, ready_err);
    end
  endtask

  task automatic test_frame_start_handshake();
    do_reset();
    wait_edge(3);
    valid_i = 1'b1; left_i = 24'h7FFFFF; right_i = 24'h800000;
    @(posedge clk); #2;
    valid_i = 1'b0;
    tests++; if (underrun_o !== 1'b1) begin fails++; $display("FAIL fs_underrun got %b want 1", underrun_o); end
    tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL fs_pending got ready %b want 0", ready_o); end
    wait_edge(515);
    tests++; if (rx_q.size() < 2) begin fails++; $display("FAIL fs_frames got %0d want 2", rx_q.size()); end
    else begin
      tests++; if (rx_q[0] !== enc(24'h0, 24'h0)) begin
        fails++; $display("FAIL fs_frame0 got %h want %h", rx_q[0], enc(24'h0, 24'h0));
      end
      tests++; if (rx_q[1] !== enc(24'h7FFFFF, 24'h800000)) begin
        fails++; $display("FAIL fs_frame1 got %h want %h", rx_q[1], enc(24'h7FFFFF, 24'h800000));
      end
    end
    tests++; if (ur_seen != 1 || ur_err != 0) begin
      fails++; $display("FAIL fs_underrun_count got %0d (%0d misplaced) want 1", ur_seen, ur_err);
    end
  endtask

  task automatic test_mid_reset();
    int first;
    first = -1;
    do_reset();
    valid_i = 1'b1; left_i = 24'h111111; right_i = 24'h222222;
    @(posedge clk); #2;
    left_i = 24'h333333; right_i = 24'h444444;
    wait_edge(5);
    valid_i = 1'b0;
    tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL mid_pending got ready %b want 0", ready_o); end
    wait_edge(173);
    #1 rst = 1'b1;
    #1;
    tests++; if (bck_o !== 1'b0 || lrck_o !== 1'b1 || dat_o !== 1'b0) begin
      fails++; $display("FAIL mid_async_outputs got bck %b lrck %b dat %b want 0 1 0", bck_o, lrck_o, dat_o);
    end
    tests++; if (ready_o !== 1'b1 || underrun_o !== 1'b0) begin
      fails++; $display("FAIL mid_async_flags got ready %b underrun %b want 1 0", ready_o, underrun_o);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < 20 && first < 0; k++) begin
      @(posedge clk); #2;
      if (lrck_o === 1'b0) first = edge_n;
    end
    tests++; if (first != 4) begin fails++; $display("FAIL mid_first_lrck_fall got edge %0d want 4", first); end
    wait_edge(515);
    tests++; if (rx_q.size() < 2) begin fails++; $display("FAIL mid_frames got %0d want 2", rx_q.size()); end
    else for (int k = 0; k < 2; k++) begin
      tests++; if (rx_q[k] !== enc(24'h0, 24'h0)) begin
        fails++; $display("FAIL mid_frame%0d got %h want %h", k, rx_q[k], enc(24'h0, 24'h0));
      end
    end
    tests++; if (ur_seen != 2 || bck_err != 0 || lrck_err != 0) begin
      fails++; $display("FAIL mid_after_release ur %0d bck_err %0d lrck_err %0d want 2/0/0", ur_seen, bck_err, lrck_err);
    end
  endtask

  task automatic test_random();
    logic rdy_s;
    int   g;
    do_reset();
    g = 0;
    while (edge_n < 1283 && g < 3000) begin
      if (valid_i == 1'b0) begin
        left_i  = 24'($urandom);
        right_i = 24'($urandom);
        if ($urandom_range(0, 99) < 3) valid_i = 1'b1;
      end
      rdy_s = ready_o;
      @(posedge clk); #2;
      g++;
      if (valid_i && rdy_s) valid_i = 1'b0;
    end
    valid_i = 1'b0;
    tests++; if (rx_q.size() < 5 || exp_q.size() < 5) begin
      fails++; $display("FAIL rand_frames got %0d decoded %0d modelled want 5", rx_q.size(), exp_q.size());
    end else for (int k = 0; k < 5; k++) begin
      tests++; if (rx_q[k] !== enc(exp_q[k][47:24], exp_q[k][23:0])) begin
        fails++; $display("FAIL rand_frame%0d got %h want %h", k, rx_q[k], enc(exp_q[k][47:24], exp_q[k][23:0]));
      end
    end
    tests++; if (ur_seen != ur_exp_cnt || ur_err != 0 || ready_err != 0 || edge_err != 0) begin
      fails++; $display("FAIL rand_protocol ur %0d want %0d, ur_err %0d ready_err %0d edge_err %0d want 0",
                        ur_seen, ur_exp_cnt, ur_err, ready_err, edge_err);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_frame_start_handshake();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
